// File: rtl/prog_bus_reader8_if.sv
`default_nettype none
// ============================================================================
//  Module      : prog_bus_reader8_if
//  Description : Control, bus and result-stream signals of prog_bus_reader8.
//                The master side issues reads and consumes results. The
//                slave side is the reader that drives oe and fills the FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
interface prog_bus_reader8_if;
    logic       start;
    logic       clr;
    logic [7:0] bus_in;
    logic       oe;
    logic       busy;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [7:0] out_delta;
    logic       drop_err;

    modport master (
        output start, clr, bus_in, out_ready,
        input  oe, busy, out_valid, out_data, out_delta, drop_err
    );

    modport slave (
        input  start, clr, bus_in, out_ready,
        output oe, busy, out_valid, out_data, out_delta, drop_err
    );
endinterface
`default_nettype wire

// File: rtl/prog_bus_reader8.sv
`default_nettype none
// ============================================================================
//  Module      : prog_bus_reader8
//  Description : Reads a shared 8-bit tri-state bus on request. It raises oe,
//                waits SETTLE cycles, samples the bus, then releases it for
//                one turnaround cycle. Each sample is queued with its delta
//                from the previous sample (modulo 256) in a small FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
module prog_bus_reader8 #(
    parameter int SETTLE = 1,   // oe-asserted cycles before the sample cycle, 1..7
    parameter int DEPTH  = 4    // result FIFO entries, power of two, 2..16
) (
    input wire                clk,
    input wire                rst,
    prog_bus_reader8_if.slave bus
);

    localparam int              c_AW          = $clog2(DEPTH);
    localparam logic [c_AW:0]   c_FULL_CNT    = (c_AW + 1)'(DEPTH);
    localparam logic [c_AW:0]   c_CNT_ONE     = (c_AW + 1)'(1);
    localparam logic [c_AW-1:0] c_PTR_ONE     = c_AW'(1);
    localparam logic [2:0]      c_SETTLE_LAST = 3'(SETTLE - 1);

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_DRIVE   = 2'd1;
    localparam logic [1:0] c_ST_SAMPLE  = 2'd2;
    localparam logic [1:0] c_ST_RELEASE = 2'd3;

    logic [1:0]      r_state;
    logic            r_oe;
    logic [2:0]      r_settle;
    logic            r_drop_err;
    logic [7:0]      r_prev;
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_AW:0]   r_count;
    logic [7:0]      r_mem_data  [0:DEPTH-1];
    logic [7:0]      r_mem_delta [0:DEPTH-1];

    logic            w_full;
    logic            w_empty;
    logic            w_push;
    logic            w_pop;
    logic [7:0]      w_delta;

    assign w_full  = (r_count == c_FULL_CNT);
    assign w_empty = (r_count == '0);
    // A read is only launched when a slot is free, and the FIFO has a single
    // writer, so the push in SAMPLE always fits. A flush cancels the push.
    assign w_push  = (r_state == c_ST_SAMPLE) && !bus.clr;
    assign w_pop   = !w_empty && bus.out_ready && !bus.clr;
    assign w_delta = bus.bus_in - r_prev;

    // Read sequencer: IDLE -> DRIVE (SETTLE cycles) -> SAMPLE -> RELEASE.
    always_ff @(posedge clk) begin
        if (rst || bus.clr) begin
            r_state    <= c_ST_IDLE;
            r_oe       <= 1'b0;
            r_settle   <= 3'd0;
            r_drop_err <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (bus.start) begin
                        if (w_full) begin
                            r_drop_err <= 1'b1;
                        end else begin
                            r_state  <= c_ST_DRIVE;
                            r_oe     <= 1'b1;
                            r_settle <= 3'd0;
                        end
                    end
                end
                c_ST_DRIVE: begin
                    if (r_settle == c_SETTLE_LAST) begin
                        r_state <= c_ST_SAMPLE;
                    end else begin
                        r_settle <= r_settle + 3'd1;
                    end
                end
                c_ST_SAMPLE: begin
                    r_state <= c_ST_RELEASE;
                    r_oe    <= 1'b0;
                end
                c_ST_RELEASE: begin
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                    r_oe    <= 1'b0;
                end
            endcase
        end
    end

    // FIFO pointers, occupancy and the previous-sample register used for delta.
    always_ff @(posedge clk) begin
        if (rst || bus.clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_prev   <= 8'h00;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
                r_prev   <= bus.bus_in;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_CNT_ONE;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - c_CNT_ONE;
            end
        end
    end

    // FIFO storage: capture the bus value and its delta at the end of SAMPLE.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_data[r_wr_ptr]  <= bus.bus_in;
            r_mem_delta[r_wr_ptr] <= w_delta;
        end
    end

    assign bus.oe        = r_oe;
    assign bus.busy      = (r_state != c_ST_IDLE);
    assign bus.drop_err  = r_drop_err;
    assign bus.out_valid = !w_empty;
    assign bus.out_data  = r_mem_data[r_rd_ptr];
    assign bus.out_delta = r_mem_delta[r_rd_ptr];

endmodule
`default_nettype wire

// File: tb/tb_prog_bus_reader8.sv
`default_nettype none
// ============================================================================
//  Module      : tb_prog_bus_reader8
//  Description : Self-checking bench for prog_bus_reader8. Reads are issued
//                by tasks that push the expected {data, delta} into a
//                scoreboard queue. A negedge monitor pops and compares on
//                every FIFO pop. A second instance with SETTLE=3 runs with
//                start held high.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_prog_bus_reader8;

    localparam int c_SETTLE  = 1;
    localparam int c_DEPTH   = 4;
    localparam int c_SETTLE3 = 3;

    typedef struct packed {
        logic [7:0] data;
        logic [7:0] delta;
    } entry_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    prog_bus_reader8_if bif ();
    prog_bus_reader8_if bif3 ();

    prog_bus_reader8 #(.SETTLE(c_SETTLE), .DEPTH(c_DEPTH)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bif.slave)
    );

    prog_bus_reader8 #(.SETTLE(c_SETTLE3), .DEPTH(c_DEPTH)) u_dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bif3.slave)
    );

    int         n_checks   = 0;
    int         n_errors   = 0;
    int         mon_checks = 0;
    int         mon_errors = 0;
    int         n_pops     = 0;
    entry_t     sb_q[$];
    entry_t     mon_e;
    logic [7:0] model_prev = 8'h00;
    bit         exp_drop   = 1'b0;
    int         ready_mode = 1;     // 0: random out_ready, 1: out_ready follows ready_force
    logic       ready_force = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // out_ready is updated 2 time units after each rising edge.
    always @(posedge clk) begin
        #2;
        if (ready_mode == 0) bif.out_ready = 1'($urandom_range(0, 1));
        else                 bif.out_ready = ready_force;
    end

    // Monitor: every pop of the FIFO head is compared with the scoreboard head.
    always @(negedge clk) begin
        if (!rst && bif.clr !== 1'b1 && bif.out_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                mon_checks++;
                mon_errors++;
                $display("FAIL mon_valid: got out_valid=1 expected empty FIFO at %0t", $time);
            end else if (bif.out_ready === 1'b1) begin
                mon_e = sb_q.pop_front();
                n_pops++;
                mon_checks++;
                if (bif.out_data !== mon_e.data) begin
                    mon_errors++;
                    $display("FAIL mon_data: got %0h expected %0h at %0t", bif.out_data, mon_e.data, $time);
                end
                mon_checks++;
                if (bif.out_delta !== mon_e.delta) begin
                    mon_errors++;
                    $display("FAIL mon_delta: got %0h expected %0h at %0t", bif.out_delta, mon_e.delta, $time);
                end
            end
        end
    end

    // One start pulse with the bus held at v, followed through to IDLE.
    task automatic do_read(input logic [7:0] v, input bit pulse_at_sample);
        bit         full_now;
        bit         was_empty;
        logic [7:0] d;
        full_now  = (sb_q.size() == c_DEPTH);
        was_empty = (sb_q.size() == 0);
        bif.bus_in = v;
        bif.start  = 1'b1;
        if (full_now) begin
            exp_drop = 1'b1;
        end else begin
            d = v - model_prev;
            sb_q.push_back('{data: v, delta: d});
            model_prev = v;
        end
        @(posedge clk); #1;
        bif.start = 1'b0;
        check("drop_err", bif.drop_err, exp_drop);
        if (full_now) begin
            for (int k = 0; k < c_SETTLE + 2; k++) begin
                check("refused_oe", bif.oe, 0);
                check("refused_busy", bif.busy, 0);
                @(posedge clk); #1;
            end
        end else begin
            for (int k = 1; k <= c_SETTLE + 1; k++) begin
                check("read_oe", bif.oe, 1);
                check("read_busy", bif.busy, 1);
                if (was_empty) check("valid_before_sample", bif.out_valid, 0);
                if (pulse_at_sample) ready_force = (k == c_SETTLE + 1);
                @(posedge clk); #1;
            end
            if (pulse_at_sample) ready_force = 1'b0;
            check("release_oe", bif.oe, 0);
            check("release_busy", bif.busy, 1);
            if (was_empty) check("valid_after_sample", bif.out_valid, 1);
            @(posedge clk); #1;
            check("idle_busy", bif.busy, 0);
        end
    endtask

    task automatic do_clr();
        bif.clr = 1'b1;
        @(posedge clk); #1;
        bif.clr = 1'b0;
        sb_q.delete();
        model_prev = 8'h00;
        exp_drop   = 1'b0;
        check("clr_valid", bif.out_valid, 0);
        check("clr_drop_err", bif.drop_err, 0);
        check("clr_oe", bif.oe, 0);
        check("clr_busy", bif.busy, 0);
    endtask

    // Start a read, then hit it with clr or rst while it is in DRIVE.
    task automatic do_abort(input logic [7:0] v, input bit use_rst);
        bif.bus_in = v;
        bif.start  = 1'b1;
        @(posedge clk); #1;
        bif.start = 1'b0;
        check("abort_drive_oe", bif.oe, 1);
        if (use_rst) rst = 1'b1;
        else         bif.clr = 1'b1;
        @(posedge clk); #1;
        rst     = 1'b0;
        bif.clr = 1'b0;
        sb_q.delete();
        model_prev = 8'h00;
        exp_drop   = 1'b0;
        check("abort_oe", bif.oe, 0);
        check("abort_busy", bif.busy, 0);
        check("abort_valid", bif.out_valid, 0);
        repeat (3) @(posedge clk);
        #1;
        check("abort_no_push", bif.out_valid, 0);
    endtask

    task automatic drain(input int cycles);
        ready_force = 1'b1;
        repeat (cycles) @(posedge clk);
        #1;
        ready_force = 1'b0;
        check("drained", sb_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish by %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         pops_before;
        int         ph;
        logic [7:0] p3;
        logic [7:0] d3;
        bif.start     = 1'b0;
        bif.clr       = 1'b0;
        bif.bus_in    = 8'h00;
        bif3.start    = 1'b0;
        bif3.clr      = 1'b0;
        bif3.bus_in   = 8'h3C;
        bif3.out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_oe", bif.oe, 0);
        check("rst_busy", bif.busy, 0);
        check("rst_valid", bif.out_valid, 0);
        check("rst_drop_err", bif.drop_err, 0);

        // Single read into an empty FIFO; head holds with out_ready low.
        do_read(8'h05, 1'b0);
        check("first_data", bif.out_data, 8'h05);
        check("first_delta", bif.out_delta, 8'h05);
        drain(3);

        // Delta wrap cases: FE then 01, FF then 02.
        do_read(8'hFE, 1'b0);
        do_read(8'h01, 1'b0);
        do_read(8'hFF, 1'b0);
        do_read(8'h02, 1'b0);
        drain(6);

        // Fill to DEPTH with no consumer; the fifth start is refused.
        do_clr();
        for (int i = 0; i < 5; i++) do_read(8'(8'hA0 + i), 1'b0);
        check("full_drop_err", bif.drop_err, 1);
        check("full_busy", bif.busy, 0);
        drain(6);
        check("drop_err_sticky", bif.drop_err, 1);

        // Three entries stored, then a push coinciding with a pop.
        do_clr();
        for (int i = 0; i < 3; i++) do_read(8'(8'h10 * (i + 1)), 1'b0);
        do_read(8'h77, 1'b1);
        pops_before = n_pops;
        drain(6);
        check("push_pop_occupancy", n_pops - pops_before, 3);

        // Abort via clr, then via rst; the next read starts from prev=0.
        do_abort(8'h5A, 1'b0);
        do_read(8'h44, 1'b0);
        check("after_clr_delta", bif.out_delta, 8'h44);
        drain(3);
        do_abort(8'h66, 1'b1);
        do_read(8'h99, 1'b0);
        check("after_rst_delta", bif.out_delta, 8'h99);
        drain(3);

        // Randomised reads with a random consumer.
        ready_mode = 0;
        for (int i = 0; i < 40; i++) begin
            do_read(8'($urandom), 1'b0);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        ready_mode = 1;
        drain(12);

        // SETTLE=3 with start held high: read period is SETTLE+3 cycles,
        // oe high for SETTLE+1 of them, one result per read.
        p3 = 8'h00;
        bif3.start = 1'b1;
        for (int c = 1; c <= 18; c++) begin
            @(posedge clk); #1;
            ph = (c - 1) % (c_SETTLE3 + 3);
            check("s3_oe", bif3.oe, (ph < c_SETTLE3 + 1));
            check("s3_busy", bif3.busy, (ph < c_SETTLE3 + 2));
            check("s3_valid", bif3.out_valid, (ph == c_SETTLE3 + 1));
            if (ph == c_SETTLE3 + 1) begin
                d3 = 8'h3C - p3;
                check("s3_data", bif3.out_data, 8'h3C);
                check("s3_delta", bif3.out_delta, d3);
                p3 = 8'h3C;
            end
        end
        bif3.start = 1'b0;

        n_errors += mon_errors;
        n_checks += mon_checks;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/prog_bus_reader8.md
PROG_BUS_READER8 -- requirements
Module: prog_bus_reader8

Interface
REQ-001 SHALL provide parameter SETTLE, default 1, meaning number of oe-asserted cycles before sampling (legal 1..7).
REQ-002 SHALL provide parameter DEPTH, default 4, meaning result FIFO entries (power of two, 2..16).
REQ-003 SHALL provide port clk, input, 1, single clock; all state on rising edge.
REQ-004 SHALL provide port rst, input, 1; reset is synchronous and active-high.
REQ-005 SHALL provide port start, input, 1, request one bus read.
REQ-006 SHALL provide port clr, input, 1, synchronous flush of FIFO, history and error flag.
REQ-007 SHALL provide port bus_in, input, 8, shared 8-bit tri-state bus being read.
REQ-008 SHALL provide port oe, output, 1, output-enable request to the bus driver (counter).
REQ-009 SHALL provide port busy, output, 1, high whenever FSM is not IDLE.
REQ-010 SHALL provide port out_valid, input-side handshake output, 1, FIFO head valid.
REQ-011 SHALL provide port out_ready, input, 1, consumer accepts FIFO head.
REQ-012 SHALL provide port out_data, output, 8, sampled bus value at FIFO head.
REQ-013 SHALL provide port out_delta, output, 8, out_data minus previous sample, modulo 256.
REQ-014 SHALL provide port drop_err, output, 1, sticky: a start was refused because FIFO full.

Function
REQ-015 SHALL implement FSM states IDLE, DRIVE, SAMPLE, RELEASE.
REQ-016 IDLE: start=1 and FIFO not full -> DRIVE next cycle; start=1 and FIFO full -> stay IDLE, set drop_err.
REQ-017 start SHALL be ignored (no error) in DRIVE, SAMPLE, RELEASE.
REQ-018 DRIVE: oe=1 for exactly SETTLE cycles (internal 3-bit settle counter), then SAMPLE.
REQ-019 SAMPLE: oe=1 for one cycle; bus_in registered at end of this cycle; push {data, delta} into FIFO; -> RELEASE.
REQ-020 RELEASE: oe=0 for one turnaround cycle; -> IDLE.
REQ-021 oe SHALL be a registered output, high only in DRIVE and SAMPLE.
REQ-022 Latency: start accepted at cycle t -> oe high t+1..t+1+SETTLE, sample taken in cycle t+1+SETTLE, out_valid high from t+2+SETTLE (FIFO previously empty); next start earliest accepted at t+3+SETTLE.
REQ-023 delta SHALL equal (sample - prev) mod 256; prev updates to sample on each push; prev=0 after reset/clr, so first delta equals sample.
REQ-024 Wrap: prev=8'hFF, sample=8'h02 -> delta=8'h03.
REQ-025 FIFO pop SHALL occur when out_valid && out_ready; out_data/out_delta show head combinationally from FIFO storage.
REQ-026 Simultaneous push and pop SHALL both succeed, occupancy unchanged.
REQ-027 Full check at start acceptance suffices (single writer); FIFO SHALL never overflow nor drop an accepted sample.
REQ-028 Pop on empty SHALL have no effect.
REQ-029 clr SHALL empty FIFO, zero prev, clear drop_err, and abort any read: FSM -> IDLE, oe=0 next cycle, no push; clr has priority over start and pop.
REQ-030 drop_err SHALL remain set until rst or clr.

Reset
REQ-031 rst=1 at a rising edge SHALL force FSM IDLE, oe=0, busy=0, out_valid=0, drop_err=0, prev=0, FIFO pointers/count=0, settle counter=0.
REQ-032 rst SHALL have priority over clr, start and out_ready; reset mid-read aborts without push.
REQ-033 out_data/out_delta values while out_valid=0 are don't-care.

Verification
REQ-034 SETTLE=1, bus_in=8'h05, start pulse at t -> oe high t+1,t+2; out_valid at t+3 with out_data=8'h05, out_delta=8'h05; busy low at t+4.
REQ-035 Two reads bus 8'hFE then 8'h01 -> second entry out_data=8'h01, out_delta=8'h03.
REQ-036 out_ready=0, DEPTH=4, five accepted-attempt start sequences -> four entries stored, fifth start refused, drop_err=1, FSM stays IDLE, oe never asserted for fifth.
REQ-037 FIFO at 3 entries, push in same cycle as pop -> count stays 3, order preserved (FIFO order checked against scoreboard).
REQ-038 rst (or clr) asserted during DRIVE -> oe=0 next cycle, no entry pushed, next read delta equals raw sample.
REQ-039 SETTLE=3, start held high continuously -> oe high 4 cycles per read, one read per 6 cycles, no start accepted while busy.
